alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised, registered successor to the single-cycle WISC ALU. Accepts one op per cycle
//  over a valid/ready handshake and holds the result in an output register with its own valid.
//  Owns the architectural Z/V/N flag register and updates it per opcode. Sits in the EX stage
//  between the ID/EX latch and the EX/MEM latch; the branch unit reads flags_* directly.
// PARAMETERS
//  WIDTH    16  datapath width; even, >=8
//  LANE_W   8   PADDSB lane width; must divide WIDTH
//  SHAMT_W  4   shift-amount width; must equal clog2(WIDTH)
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous reset, active-high
//  in_valid   in   1        op/src0/src1/shamt valid this cycle
//  in_ready   out  1        block can accept an op this cycle
//  op         in   4        opcode (codes below)
//  src0       in   WIDTH    operand 0 / shift source
//  src1       in   WIDTH    operand 1 / immediate
//  shamt      in   SHAMT_W  shift amount
//  flush      in   1        kill the held result (branch mispredict)
//  out_valid  out  1        dst is valid
//  out_ready  in   1        downstream accepts dst this cycle
//  dst        out  WIDTH    registered result
//  flag_z     out  1        zero flag (registered)
//  flag_v     out  1        overflow flag (registered)
//  flag_n     out  1        negative flag (registered)
// BEHAVIOUR
//  Opcodes: 0 ADD, 1 PADDSB, 2 SUB, 3 AND, 4 NOR, 5 SLL, 6 SRL, 7 SRA, 8 LW, 9 SW,
//   A LHB, B LLB, C B, D JAL, E JR, F HLT.
//  Reset: out_valid=0, dst=0, flag_z=flag_v=flag_n=0; takes effect immediately (async).
//  Handshake: in_ready = !out_valid | out_ready. Op accepted when in_valid & in_ready.
//  Latency: 1 cycle; accepted op -> dst/out_valid on the next edge. Full throughput.
//  Hold: out_valid & !out_ready -> dst and out_valid stable; in_ready=0.
//  Output update per edge: accept -> out_valid<=1, dst<=result; else if out_ready -> out_valid<=0.
//  Arithmetic:
//   ADD/SUB: signed WIDTH-bit add / src0-src1, saturated to +max/-min on overflow.
//   PADDSB: WIDTH/LANE_W independent signed saturating lane adds, no cross-lane carry.
//   LW/SW: plain wrapping src0+src1 (address), never saturated.
//   AND: src0&src1. NOR: ~(src0|src1).
//   SLL/SRL/SRA: src0 shifted by shamt; SRA sign-fills; shamt=0 -> src0.
//   LHB: {src1[H-1:0], src0[H-1:0]}, H=WIDTH/2. LLB: src1[H-1:0] sign-extended.
//   B/JAL/JR/HLT: dst=src0.
//  Flags (written on the same edge the op is accepted, from the final result):
//   ADD/SUB: Z=(res==0), V=signed overflow before saturation, N=res[WIDTH-1].
//   AND/NOR/SLL/SRL/SRA: Z only; V, N hold.
//   All other ops: no flag change.
//  Flush: on an edge with flush=1, out_valid<=0 and no flags are written. Any op presented on
//   that same cycle is dropped (in_ready stays per formula; accept is ignored). Flags written
//   by earlier accepted ops are not rolled back.
//  Simultaneous out_ready & accept: the new result replaces the old one; no bubble.
//  Reset mid-operation: the held result is lost, flags clear, and in_ready=1 after release.
// STRUCTURE
//  Package alu_pkg: opcode localparams (ADD..HLT), alu_op_t 4-bit typedef, and a
//   flag-update-class function (NONE / Z_ONLY / ZVN) indexed by opcode.
//  One sub-module alu_core: purely combinational (op, src0, src1, shamt) ->
//   (result, z, v, n, flag_class). alu_pipe owns the handshake, output register and flags.
// TESTING
//  1. WIDTH=16: ADD 0x7FFF+0x0001 -> dst=0x7FFF, V=1, N=0, Z=0; SUB 0x8000-0x0001 -> 0x8000, V=1, N=1.
//  2. PADDSB 0x7F80+0x0180 (LANE_W=8) -> dst=0x7F80; flags unchanged from the prior ADD.
//  3. Back-pressure: out_ready=0 for 3 cycles with in_valid=1 -> dst stable, in_ready=0,
//     one op accepted; release -> next op lands the following cycle.
//  4. AND 0x00F0&0x0F00 -> Z=1 with V/N held; then SRA 0x8000 by 15 -> dst=0xFFFF, Z=0.
//  5. Flush with out_valid=1 plus a new ADD on the same cycle -> out_valid=0 next cycle,
//     flags unchanged.
//  6. Assert rst mid-stream (async, between edges) -> out_valid=0, dst=0, flags=0 at once;
//     WIDTH=32 repeat of test 1 -> 0x7FFFFFFF.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined WISC ALU: opcode encodings,
// flag-update classes and the opcode -> flag-class lookup.
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t OP_ADD    = 4'h0;
    localparam alu_op_t OP_PADDSB = 4'h1;
    localparam alu_op_t OP_SUB    = 4'h2;
    localparam alu_op_t OP_AND    = 4'h3;
    localparam alu_op_t OP_NOR    = 4'h4;
    localparam alu_op_t OP_SLL    = 4'h5;
    localparam alu_op_t OP_SRL    = 4'h6;
    localparam alu_op_t OP_SRA    = 4'h7;
    localparam alu_op_t OP_LW     = 4'h8;
    localparam alu_op_t OP_SW     = 4'h9;
    localparam alu_op_t OP_LHB    = 4'hA;
    localparam alu_op_t OP_LLB    = 4'hB;
    localparam alu_op_t OP_B      = 4'hC;
    localparam alu_op_t OP_JAL    = 4'hD;
    localparam alu_op_t OP_JR     = 4'hE;
    localparam alu_op_t OP_HLT    = 4'hF;

    // Which architectural flags an opcode is allowed to write.
    typedef enum logic [1:0] {
        FC_NONE   = 2'd0,
        FC_Z_ONLY = 2'd1,
        FC_ZVN    = 2'd2
    } flag_class_t;

    // Arithmetic ops write all three flags, logic/shift ops only Z,
    // address/load-immediate/control ops leave the flags alone.
    function automatic flag_class_t flag_class_of(input alu_op_t op);
        flag_class_t fc;
        case (op)
            OP_ADD, OP_SUB:                          fc = FC_ZVN;
            OP_AND, OP_NOR, OP_SLL, OP_SRL, OP_SRA:  fc = FC_Z_ONLY;
            default:                                 fc = FC_NONE;
        endcase
        return fc;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: computes the result, candidate
// Z/V/N flags and the flag-update class for one op.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int LANE_W  = 8,
    parameter int SHAMT_W = 4
) (
    input  alu_op_t              i_op,
    input  logic [WIDTH-1:0]     i_src0,
    input  logic [WIDTH-1:0]     i_src1,
    input  logic [SHAMT_W-1:0]   i_shamt,
    output logic [WIDTH-1:0]     o_result,
    output logic                 o_z,
    output logic                 o_v,
    output logic                 o_n,
    output flag_class_t          o_flag_class
);

    localparam int H     = WIDTH / 2;
    localparam int LANES = WIDTH / LANE_W;

    localparam logic [WIDTH-1:0]  SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]  SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [LANE_W-1:0] LANE_MAX = {1'b0, {(LANE_W-1){1'b1}}};
    localparam logic [LANE_W-1:0] LANE_MIN = {1'b1, {(LANE_W-1){1'b0}}};

    logic [WIDTH-1:0] w_add_raw;
    logic [WIDTH-1:0] w_sub_raw;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic [WIDTH-1:0] w_add_sat;
    logic [WIDTH-1:0] w_sub_sat;
    logic [WIDTH-1:0] w_paddsb;
    logic [WIDTH-1:0] w_sra;
    logic [LANE_W-1:0] w_lane_a;
    logic [LANE_W-1:0] w_lane_b;
    logic [LANE_W-1:0] w_lane_s;

    // Wrapping sum/difference; also used unsaturated for LW/SW addresses.
    assign w_add_raw = i_src0 + i_src1;
    assign w_sub_raw = i_src0 - i_src1;

    // Signed overflow: operands agree (add) / differ (sub) in sign and the
    // raw result's sign differs from src0.
    assign w_add_ovf = (i_src0[WIDTH-1] == i_src1[WIDTH-1]) &&
                       (w_add_raw[WIDTH-1] != i_src0[WIDTH-1]);
    assign w_sub_ovf = (i_src0[WIDTH-1] != i_src1[WIDTH-1]) &&
                       (w_sub_raw[WIDTH-1] != i_src0[WIDTH-1]);

    // On overflow the direction is given by src0's sign.
    assign w_add_sat = w_add_ovf ? (i_src0[WIDTH-1] ? SAT_MIN : SAT_MAX) : w_add_raw;
    assign w_sub_sat = w_sub_ovf ? (i_src0[WIDTH-1] ? SAT_MIN : SAT_MAX) : w_sub_raw;

    assign w_sra = $unsigned($signed(i_src0) >>> i_shamt);

    // Independent per-lane saturating adds; no carry crosses a lane boundary.
    always_comb begin
        w_paddsb = '0;
        w_lane_a = '0;
        w_lane_b = '0;
        w_lane_s = '0;
        for (int i = 0; i < LANES; i++) begin
            w_lane_a = i_src0[i*LANE_W +: LANE_W];
            w_lane_b = i_src1[i*LANE_W +: LANE_W];
            w_lane_s = w_lane_a + w_lane_b;
            if ((w_lane_a[LANE_W-1] == w_lane_b[LANE_W-1]) &&
                (w_lane_s[LANE_W-1] != w_lane_a[LANE_W-1])) begin
                w_lane_s = w_lane_a[LANE_W-1] ? LANE_MIN : LANE_MAX;
            end
            w_paddsb[i*LANE_W +: LANE_W] = w_lane_s;
        end
    end

    // Result mux and the overflow flag that goes with it.
    always_comb begin
        o_result = i_src0;
        o_v      = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_result = w_add_sat;
                o_v      = w_add_ovf;
            end
            OP_SUB: begin
                o_result = w_sub_sat;
                o_v      = w_sub_ovf;
            end
            OP_PADDSB:    o_result = w_paddsb;
            OP_AND:       o_result = i_src0 & i_src1;
            OP_NOR:       o_result = ~(i_src0 | i_src1);
            OP_SLL:       o_result = i_src0 << i_shamt;
            OP_SRL:       o_result = i_src0 >> i_shamt;
            OP_SRA:       o_result = w_sra;
            OP_LW, OP_SW: o_result = w_add_raw;
            OP_LHB:       o_result = {i_src1[H-1:0], i_src0[H-1:0]};
            OP_LLB:       o_result = {{H{i_src1[H-1]}}, i_src1[H-1:0]};
            default:      o_result = i_src0;
        endcase
    end

    assign o_z          = (o_result == '0);
    assign o_n          = o_result[WIDTH-1];
    assign o_flag_class = flag_class_of(i_op);

endmodule

// File: rtl/alu_pipe.sv
// Registered EX-stage ALU: valid/ready input, one-entry output register
// with its own valid, and the architectural Z/V/N flag register.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int LANE_W  = 8,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   src0,
    input  logic [WIDTH-1:0]   src1,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   dst,
    output logic               flag_z,
    output logic               flag_v,
    output logic               flag_n
);

    // Handshake: an op transfers on an edge where in_valid & in_ready;
    // dst transfers where out_valid & out_ready. in_ready is high whenever
    // the output register is empty or being drained this cycle, so a new
    // result can replace a consumed one with no bubble. While
    // out_valid & !out_ready, dst and out_valid are held and in_ready=0.
    // flush overrides an accept on the same edge: the op is dropped.

    logic [WIDTH-1:0] w_result;
    logic             w_z;
    logic             w_v;
    logic             w_n;
    flag_class_t      w_fclass;
    logic             w_accept;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_dst;
    logic             r_flag_z;
    logic             r_flag_v;
    logic             r_flag_n;

    alu_core #(
        .WIDTH   (WIDTH),
        .LANE_W  (LANE_W),
        .SHAMT_W (SHAMT_W)
    ) u_core (
        .i_op         (op),
        .i_src0       (src0),
        .i_src1       (src1),
        .i_shamt      (shamt),
        .o_result     (w_result),
        .o_z          (w_z),
        .o_v          (w_v),
        .o_n          (w_n),
        .o_flag_class (w_fclass)
    );

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready && !flush;

    // Output register: load on accept, drain on out_ready, kill on flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_dst       <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_dst       <= w_result;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Flag register: written only by accepted ops, per their flag class.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flag_z <= 1'b0;
            r_flag_v <= 1'b0;
            r_flag_n <= 1'b0;
        end else if (w_accept) begin
            case (w_fclass)
                FC_ZVN: begin
                    r_flag_z <= w_z;
                    r_flag_v <= w_v;
                    r_flag_n <= w_n;
                end
                FC_Z_ONLY: begin
                    r_flag_z <= w_z;
                end
                default: begin
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign dst       = r_dst;
    assign flag_z    = r_flag_z;
    assign flag_v    = r_flag_v;
    assign flag_n    = r_flag_n;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed testbench for alu_pipe: WIDTH=16 instance for the main tests
// and a WIDTH=32 instance for the wide saturation repeat.
module tb_alu_pipe;

    logic        clk;
    logic        rst;

    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [15:0] src0;
    logic [15:0] src1;
    logic [3:0]  shamt;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] dst;
    logic        flag_z;
    logic        flag_v;
    logic        flag_n;

    logic        in_valid_32;
    logic        in_ready_32;
    logic [3:0]  op_32;
    logic [31:0] src0_32;
    logic [31:0] src1_32;
    logic [4:0]  shamt_32;
    logic        flush_32;
    logic        out_valid_32;
    logic        out_ready_32;
    logic [31:0] dst_32;
    logic        flag_z_32;
    logic        flag_v_32;
    logic        flag_n_32;

    int n_checks;
    int n_errors;

    alu_pipe #(.WIDTH(16), .LANE_W(8), .SHAMT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src0      (src0),
        .src1      (src1),
        .shamt     (shamt),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dst       (dst),
        .flag_z    (flag_z),
        .flag_v    (flag_v),
        .flag_n    (flag_n)
    );

    alu_pipe #(.WIDTH(32), .LANE_W(8), .SHAMT_W(5)) dut32 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_32),
        .in_ready  (in_ready_32),
        .op        (op_32),
        .src0      (src0_32),
        .src1      (src1_32),
        .shamt     (shamt_32),
        .flush     (flush_32),
        .out_valid (out_valid_32),
        .out_ready (out_ready_32),
        .dst       (dst_32),
        .flag_z    (flag_z_32),
        .flag_v    (flag_v_32),
        .flag_n    (flag_n_32)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one op to the 16-bit instance for exactly one edge.
    task automatic issue(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] sh);
        @(negedge clk);
        op       = o;
        src0     = a;
        src1     = b;
        shamt    = sh;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic issue32(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_32       = o;
        src0_32     = a;
        src1_32     = b;
        shamt_32    = '0;
        in_valid_32 = 1'b1;
        @(posedge clk);
        #1;
        in_valid_32 = 1'b0;
    endtask

    // Check dst, out_valid and packed {z,v,n} of the 16-bit instance.
    task automatic expect16(input string tag, input logic [15:0] d, input logic [2:0] zvn);
        check({tag, "_dst"}, {16'h0, dst}, {16'h0, d});
        check({tag, "_vld"}, {31'h0, out_valid}, 32'd1);
        check({tag, "_zvn"}, {29'h0, flag_z, flag_v, flag_n}, {29'h0, zvn});
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        op          = '0;
        src0        = '0;
        src1        = '0;
        shamt       = '0;
        flush       = 1'b0;
        out_ready   = 1'b1;
        in_valid_32 = 1'b0;
        op_32       = '0;
        src0_32     = '0;
        src1_32     = '0;
        shamt_32    = '0;
        flush_32    = 1'b0;
        out_ready_32 = 1'b1;

        // Reset state
        #1;
        check("rst_vld",   {31'h0, out_valid}, 32'd0);
        check("rst_dst",   {16'h0, dst}, 32'h0);
        check("rst_zvn",   {29'h0, flag_z, flag_v, flag_n}, 32'h0);
        check("rst_ready", {31'h0, in_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Saturating add/sub
        issue(4'h0, 16'h7FFF, 16'h0001, 4'd0);  expect16("add_sat", 16'h7FFF, 3'b010);
        issue(4'h2, 16'h8000, 16'h0001, 4'd0);  expect16("sub_sat", 16'h8000, 3'b011);
        issue(4'h0, 16'h7FFF, 16'h0001, 4'd0);  expect16("add_sat2", 16'h7FFF, 3'b010);

        // PADDSB saturates each lane, flags untouched
        issue(4'h1, 16'h7F80, 16'h0180, 4'd0);  expect16("paddsb_sat", 16'h7F80, 3'b010);

        // Logic/shift ops: Z only
        issue(4'h3, 16'h00F0, 16'h0F00, 4'd0);  expect16("and_zero", 16'h0000, 3'b110);
        issue(4'h7, 16'h8000, 16'h0000, 4'd15); expect16("sra15", 16'hFFFF, 3'b010);
        issue(4'h5, 16'h0001, 16'h0000, 4'd4);  expect16("sll4", 16'h0010, 3'b010);
        issue(4'h5, 16'h1234, 16'h0000, 4'd0);  expect16("sll0", 16'h1234, 3'b010);
        issue(4'h6, 16'h8000, 16'h0000, 4'd15); expect16("srl15", 16'h0001, 3'b010);
        issue(4'h4, 16'h0000, 16'h0000, 4'd0);  expect16("nor", 16'hFFFF, 3'b010);

        // Non-saturating arithmetic
        issue(4'h0, 16'h0001, 16'hFFFF, 4'd0);  expect16("add_zero", 16'h0000, 3'b100);
        issue(4'h2, 16'h0005, 16'h0007, 4'd0);  expect16("sub_neg", 16'hFFFE, 3'b001);

        // Address, load-immediate and control ops leave flags alone
        issue(4'h8, 16'h7FFF, 16'h0001, 4'd0);  expect16("lw_wrap", 16'h8000, 3'b001);
        issue(4'hA, 16'h1234, 16'hAB56, 4'd0);  expect16("lhb", 16'h5634, 3'b001);
        issue(4'hB, 16'h0000, 16'h0080, 4'd0);  expect16("llb", 16'hFF80, 3'b001);
        issue(4'hE, 16'hBEEF, 16'h1111, 4'd0);  expect16("jr", 16'hBEEF, 3'b001);
        issue(4'h1, 16'h0102, 16'h0304, 4'd0);  expect16("paddsb", 16'h0406, 3'b001);

        // Back-pressure: held result, no accept for three edges
        @(negedge clk);
        out_ready = 1'b0;
        op        = 4'h0;
        src0      = 16'h0001;
        src1      = 16'h0002;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp_ready", {31'h0, in_ready}, 32'd0);
            expect16("bp_hold", 16'h0406, 3'b001);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'h0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        expect16("bp_land", 16'h0003, 3'b000);

        // Drain with nothing new
        @(posedge clk);
        #1;
        check("drain_vld", {31'h0, out_valid}, 32'd0);

        // Flush drops the op on the same edge and keeps flags
        issue(4'h2, 16'h0005, 16'h0007, 4'd0);  expect16("pre_flush", 16'hFFFE, 3'b001);
        @(negedge clk);
        flush    = 1'b1;
        op       = 4'h0;
        src0     = 16'h7FFF;
        src1     = 16'h0001;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_vld", {31'h0, out_valid}, 32'd0);
        check("flush_zvn", {29'h0, flag_z, flag_v, flag_n}, 32'h1);

        // Asynchronous reset between edges
        issue(4'h0, 16'h7FFF, 16'h0001, 4'd0);  expect16("pre_rst", 16'h7FFF, 3'b010);
        #3;
        rst = 1'b1;
        #1;
        check("arst_vld", {31'h0, out_valid}, 32'd0);
        check("arst_dst", {16'h0, dst}, 32'h0);
        check("arst_zvn", {29'h0, flag_z, flag_v, flag_n}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_ready", {31'h0, in_ready}, 32'd1);

        // 32-bit saturation
        issue32(4'h0, 32'h7FFFFFFF, 32'h00000001);
        check("add32_dst", dst_32, 32'h7FFFFFFF);
        check("add32_vld", {31'h0, out_valid_32}, 32'd1);
        check("add32_zvn", {29'h0, flag_z_32, flag_v_32, flag_n_32}, 32'h2);
        issue32(4'h2, 32'h80000000, 32'h00000001);
        check("sub32_dst", dst_32, 32'h80000000);
        check("sub32_zvn", {29'h0, flag_z_32, flag_v_32, flag_n_32}, 32'h3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
